// File: rtl/led_tx_pkg.sv
// Shared definitions for the LED serial transmitter: state encoding and a
// constant ceil-log2 helper used to size the internal counters.
package led_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_LATCH    = 2'd3
    } state_t;

    // Ceil(log2(value)), never less than 1 so counters always have a bit.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/led_tx_tick.sv
// Reloadable divide-by-DIV tick counter. tick is high on the last cycle of
// each DIV-cycle window; restart forces the window to begin again at 0.
module led_tx_tick
    import led_tx_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clock,
    input  logic clr,
    input  logic restart,
    output logic tick
);

    localparam int             CW   = clog2(DIV + 1);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    // Count up through the window, reloading on restart or at its end.
    always_ff @(posedge clock) begin
        if (clr || restart || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_shift_tx.sv
// Bit-serial LED pattern transmitter for a 74HC595-style receiver chain.
// Accepts one WIDTH-bit word, shifts it out on sdata with a self-generated
// sclk (DIV system cycles per half period), then strobes latch for DIV cycles.
// Build option: define LED_SHIFT_TX_LSB_FIRST_EN to send load_data[0] first;
// by default the word leaves MSB-first.
module led_shift_tx
    import led_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 2
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy
);

    localparam int            BW       = clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_tick;
    logic             w_accept;
    logic             w_advance;
    logic             w_restart;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_shift;
    logic             r_sclk;
    logic             r_sdata;
    logic             r_latch;
    logic             r_busy;

    assign load_ready = (r_state == ST_IDLE) && !clr;
    assign w_accept   = load_valid && load_ready;
    // Moving on to the next bit happens only when a high phase ends early
    // in the word; the final high phase goes to LATCH instead.
    assign w_advance  = (r_state == ST_SHIFT_HI) && w_tick && (r_bit != LAST_BIT);
    // Every state change starts a fresh DIV window.
    assign w_restart  = (w_state_next != r_state);

    assign sclk  = r_sclk;
    assign sdata = r_sdata;
    assign latch = r_latch;
    assign busy  = r_busy;

    led_tx_tick #(
        .DIV (DIV)
    ) u_tick (
        .clock   (clock),
        .clr     (clr),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: each active state lasts one DIV window.
    always_comb begin
        w_state_next = r_state;
        if (clr) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (w_accept) w_state_next = ST_SHIFT_LO;
                ST_SHIFT_LO: if (w_tick)   w_state_next = ST_SHIFT_HI;
                ST_SHIFT_HI: if (w_tick)   w_state_next = (r_bit == LAST_BIT) ? ST_LATCH : ST_SHIFT_LO;
                ST_LATCH:    if (w_tick)   w_state_next = ST_IDLE;
                default:                   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Registered outputs track the next state so they line up with it;
    // sdata is only updated on entry to SHIFT_LO, so it is steady across
    // the whole high phase of sclk.
    always_ff @(posedge clock) begin
        if (clr) begin
            r_sclk  <= 1'b0;
            r_sdata <= 1'b0;
            r_latch <= 1'b0;
            r_busy  <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sclk  <= (w_state_next == ST_SHIFT_HI);
            r_latch <= (w_state_next == ST_LATCH);
            r_busy  <= (w_state_next != ST_IDLE);
            if (w_accept) begin
                r_bit <= '0;
`ifdef LED_SHIFT_TX_LSB_FIRST_EN
                r_sdata <= load_data[0];
                r_shift <= {1'b0, load_data[WIDTH-1:1]};
`else
                r_sdata <= load_data[WIDTH-1];
                r_shift <= {load_data[WIDTH-2:0], 1'b0};
`endif
            end else if (w_advance) begin
                r_bit <= r_bit + BW'(1);
`ifdef LED_SHIFT_TX_LSB_FIRST_EN
                r_sdata <= r_shift[0];
                r_shift <= {1'b0, r_shift[WIDTH-1:1]};
`else
                r_sdata <= r_shift[WIDTH-1];
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
`endif
            end
        end
    end

endmodule

// File: tb/tb_led_shift_tx.sv
// Directed bench for led_shift_tx: an 8-bit/DIV=2 instance and a 4-bit/DIV=1
// instance, each watched by a 74HC595-style receiver model.
module tb_led_shift_tx;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       clr;
    logic       lv8, lr8, sclk8, sdata8, latch8, busy8;
    logic [7:0] ld8;
    logic       lv4, lr4, sclk4, sdata4, latch4, busy4;
    logic [3:0] ld4;

    led_shift_tx #(.WIDTH(8), .DIV(2)) u_dut8 (
        .clock(clock), .clr(clr), .load_valid(lv8), .load_ready(lr8),
        .load_data(ld8), .sclk(sclk8), .sdata(sdata8), .latch(latch8), .busy(busy8)
    );

    led_shift_tx #(.WIDTH(4), .DIV(1)) u_dut4 (
        .clock(clock), .clr(clr), .load_valid(lv4), .load_ready(lr4),
        .load_data(ld4), .sclk(sclk4), .sdata(sdata4), .latch(latch4), .busy(busy4)
    );

    // ---------------- receiver models (sampled on negedge) ----------------
    logic [7:0] rx_sh8 = '0, rx_out8 = '0;
    logic       p_sclk8 = 0, p_sdata8 = 0, p_latch8 = 0, first8 = 0, armed8 = 1;
    int         rises8 = 0, latches8 = 0, busy_cyc8 = 0, latch_cyc8 = 0, hold_err8 = 0;

    always @(negedge clock) begin
        if (!busy8) armed8 <= 1'b1;
        if (sclk8 && !p_sclk8) begin
            rx_sh8 <= {rx_sh8[6:0], sdata8};
            rises8 <= rises8 + 1;
            if (armed8) begin
                first8 <= sdata8;
                armed8 <= 1'b0;
            end
        end
        if (sclk8 && (sdata8 != p_sdata8)) hold_err8 <= hold_err8 + 1;
        if (latch8 && !p_latch8) begin
            rx_out8  <= rx_sh8;
            latches8 <= latches8 + 1;
        end
        if (latch8) latch_cyc8 <= latch_cyc8 + 1;
        if (busy8)  busy_cyc8  <= busy_cyc8 + 1;
        p_sclk8  <= sclk8;
        p_sdata8 <= sdata8;
        p_latch8 <= latch8;
    end

    logic [3:0] rx_sh4 = '0, rx_out4 = '0;
    logic       p_sclk4 = 0, p_latch4 = 0, p_busy4 = 0;
    int         rises4 = 0, busy_cyc4 = 0, latch_cyc4 = 0, toggle_err4 = 0;

    always @(negedge clock) begin
        if (sclk4 && !p_sclk4) begin
            rx_sh4 <= {rx_sh4[2:0], sdata4};
            rises4 <= rises4 + 1;
        end
        if (latch4 && !p_latch4) rx_out4 <= rx_sh4;
        if (busy4 && p_busy4 && !latch4 && !p_latch4 && (sclk4 == p_sclk4))
            toggle_err4 <= toggle_err4 + 1;
        if (latch4) latch_cyc4 <= latch_cyc4 + 1;
        if (busy4)  busy_cyc4  <= busy_cyc4 + 1;
        p_sclk4  <= sclk4;
        p_latch4 <= latch4;
        p_busy4  <= busy4;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic send8(input logic [7:0] d);
        int n = 0;
        while (!lr8 && n < 100) begin @(negedge clock); n++; end
        check("send8 ready", 32'(lr8), 32'd1);
        lv8 = 1'b1;
        ld8 = d;
        @(negedge clock);
        lv8 = 1'b0;
        check("send8 accepted busy", 32'(busy8), 32'd1);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 200) begin @(negedge clock); n++; end
        check("idle8 reached", 32'(busy8), 32'd0);
    endtask

    task automatic send4(input logic [3:0] d);
        int n = 0;
        while (!lr4 && n < 100) begin @(negedge clock); n++; end
        check("send4 ready", 32'(lr4), 32'd1);
        lv4 = 1'b1;
        ld4 = d;
        @(negedge clock);
        lv4 = 1'b0;
        n = 0;
        while (busy4 && n < 100) begin @(negedge clock); n++; end
        check("idle4 reached", 32'(busy4), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_rx;
        logic       exp_first;
    } vec_t;

    vec_t       vecs[4];
    logic [3:0] v4_data[2];
    logic [3:0] v4_exp[2];
    int         s_busy, s_lat, s_lcyc, s_rise, s_hold, s_tog, n, r;
    logic       ps;

    initial begin
        clr = 1'b1; lv8 = 1'b0; ld8 = '0; lv4 = 1'b0; ld4 = '0;
`ifdef LED_SHIFT_TX_LSB_FIRST_EN
        vecs[0] = '{8'hA5, 8'hA5, 1'b1};
        vecs[1] = '{8'h01, 8'h80, 1'b1};
        vecs[2] = '{8'h12, 8'h48, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1};
        v4_data[0] = 4'b1001; v4_exp[0] = 4'b1001;
        v4_data[1] = 4'b0011; v4_exp[1] = 4'b1100;
`else
        vecs[0] = '{8'hA5, 8'hA5, 1'b1};
        vecs[1] = '{8'h01, 8'h01, 1'b0};
        vecs[2] = '{8'h12, 8'h12, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1};
        v4_data[0] = 4'b1001; v4_exp[0] = 4'b1001;
        v4_data[1] = 4'b0011; v4_exp[1] = 4'b0011;
`endif

        // Reset state
        repeat (3) @(negedge clock);
        check("rst sclk", 32'(sclk8), 32'd0);
        check("rst sdata", 32'(sdata8), 32'd0);
        check("rst latch", 32'(latch8), 32'd0);
        check("rst busy", 32'(busy8), 32'd0);
        check("rst load_ready low in clr", 32'(lr8), 32'd0);
        check("rst busy4", 32'(busy4), 32'd0);
        clr = 1'b0;
        @(negedge clock);
        check("load_ready after clr", 32'(lr8), 32'd1);

        // Table-driven single transfers
        for (int i = 0; i < 4; i++) begin
            s_busy = busy_cyc8; s_lat = latches8; s_lcyc = latch_cyc8;
            s_rise = rises8;    s_hold = hold_err8;
            send8(vecs[i].data);
            wait_idle8();
            check("vec rx word", 32'(rx_out8), 32'(vecs[i].exp_rx));
            check("vec first bit", 32'(first8), 32'(vecs[i].exp_first));
            check("vec busy cycles", busy_cyc8 - s_busy, 32'd34);
            check("vec latch pulses", latches8 - s_lat, 32'd1);
            check("vec latch cycles", latch_cyc8 - s_lcyc, 32'd2);
            check("vec sclk rises", rises8 - s_rise, 32'd8);
            check("vec sdata stable while sclk high", hold_err8 - s_hold, 32'd0);
            check("vec load_ready back", 32'(lr8), 32'd1);
        end

        // Back-to-back: FF then 00 with load_valid held
        s_lat = latches8;
        lv8 = 1'b1; ld8 = 8'hFF;
        @(negedge clock);
        check("b2b first accept", 32'(busy8), 32'd1);
        ld8 = 8'h00;
        n = 0;
        while (busy8 && n < 200) begin @(negedge clock); n++; end
        check("b2b first idle reached", 32'(busy8), 32'd0);
        check("b2b ready on first idle", 32'(lr8), 32'd1);
        check("b2b first word", 32'(rx_out8), 32'hFF);
        @(negedge clock);
        check("b2b second accept", 32'(busy8), 32'd1);
        lv8 = 1'b0;
        wait_idle8();
        check("b2b second word", 32'(rx_out8), 32'h00);
        check("b2b first bit", 32'(first8), 32'd0);
        check("b2b latch pulses", latches8 - s_lat, 32'd2);

        // load_valid during a transfer is ignored
        s_lat = latches8; s_busy = busy_cyc8;
        send8(8'hA5);
        repeat (10) @(negedge clock);
        lv8 = 1'b1; ld8 = 8'h3C;
        @(negedge clock);
        lv8 = 1'b0;
        wait_idle8();
        check("ignore rx word", 32'(rx_out8), 32'hA5);
        check("ignore busy cycles", busy_cyc8 - s_busy, 32'd34);
        repeat (5) @(negedge clock);
        check("ignore no extra transfer", 32'(busy8), 32'd0);
        check("ignore latch pulses", latches8 - s_lat, 32'd1);

        // clr at the 5th sclk rise
        s_lat = latches8;
        send8(8'hFF);
        n = 0; r = 0;
        while (r < 5 && n < 200) begin
            ps = sclk8;
            @(negedge clock);
            n++;
            if (sclk8 && !ps) r++;
        end
        check("clr saw 5 rises", r, 32'd5);
        clr = 1'b1;
        @(negedge clock);
        check("clr sclk", 32'(sclk8), 32'd0);
        check("clr sdata", 32'(sdata8), 32'd0);
        check("clr latch", 32'(latch8), 32'd0);
        check("clr busy", 32'(busy8), 32'd0);
        check("clr load_ready", 32'(lr8), 32'd0);
        clr = 1'b0;
        repeat (5) @(negedge clock);
        check("clr no latch pulse", latches8 - s_lat, 32'd0);
        send8(8'h81);
        wait_idle8();
        check("after clr rx word", 32'(rx_out8), 32'h81);
        check("after clr latch pulses", latches8 - s_lat, 32'd1);

        // DIV=1, WIDTH=4 instance
        for (int i = 0; i < 2; i++) begin
            s_busy = busy_cyc4; s_rise = rises4; s_lcyc = latch_cyc4; s_tog = toggle_err4;
            send4(v4_data[i]);
            check("div1 rx word", 32'(rx_out4), 32'(v4_exp[i]));
            check("div1 busy cycles", busy_cyc4 - s_busy, 32'd9);
            check("div1 sclk rises", rises4 - s_rise, 32'd4);
            check("div1 latch cycles", latch_cyc4 - s_lcyc, 32'd1);
            check("div1 sclk toggles each cycle", toggle_err4 - s_tog, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
